// File: rtl/jtpang_objdma.sv
// Object-table DMA: on a go edge it takes the Z80 bus, copies LEN bytes of VRAM
// into the back page of the object line buffer, then releases the bus and flips pages.
module jtpang_objdma #(
  parameter int          LEN      = 512,
  parameter int          AW       = 9,
  parameter logic [11:0] SRC_BASE = 12'h000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic          dma_bus,
  output logic [11:0]   dma_addr,
  input  logic [7:0]    dma_din,
  output logic [AW:0]   buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          obj_page,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, REL} state_t;

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  state_t        st;
  logic          go_s, go_d, pend;
  logic [AW-1:0] idx;
  logic          go_edge;

  assign go_edge = go_s & ~go_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      go_s     <= 1'b0;
      go_d     <= 1'b0;
      pend     <= 1'b0;
      idx      <= '0;
      busrq_n  <= 1'b1;
      dma_bus  <= 1'b0;
      dma_addr <= SRC_BASE;
      buf_addr <= '0;
      buf_din  <= '0;
      buf_we   <= 1'b0;
      obj_page <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      go_s   <= dma_go;
      go_d   <= go_s;
      done   <= 1'b0;
      buf_we <= 1'b0;
      // edges seen while busy collapse into one queued transfer
      if (go_edge && st != IDLE) pend <= 1'b1;
      case (st)
        IDLE: if (go_edge) begin
          st      <= REQ;
          busy    <= 1'b1;
          busrq_n <= 1'b0;
        end
        REQ: begin
          busrq_n <= 1'b0;
          if (!busak_n) begin
            st      <= ADDR;
            idx     <= '0;
            dma_bus <= 1'b1;
          end
        end
        // both data states stall while the CPU holds the bus
        ADDR: if (!busak_n && cen) begin
          dma_addr <= SRC_BASE + 12'(idx);
          st       <= DATA;
        end
        DATA: if (!busak_n && cen) begin
          buf_din  <= dma_din;
          buf_addr <= {~obj_page, idx};
          buf_we   <= 1'b1;
          if (idx == LAST) begin
            st      <= REL;
            dma_bus <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
            st  <= ADDR;
          end
        end
        REL: begin
          busrq_n  <= 1'b1;
          obj_page <= ~obj_page;
          done     <= 1'b1;
          pend     <= 1'b0;
          if (pend || go_edge) begin
            st   <= REQ;
            busy <= 1'b1;
          end else begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Randomised scoreboard bench for jtpang_objdma: expected buffer writes and page
// flips are queued from a VRAM reference model and checked by an output monitor.
module tb_jtpang_objdma;
  localparam int          LEN = 8;
  localparam int          AW  = 3;
  localparam logic [11:0] SRC = 12'h100;

  logic clk = 1'b0, rst = 1'b1, cen = 1'b0, dma_go = 1'b0, busak_n = 1'b1;
  logic busrq_n, dma_bus, buf_we, obj_page, busy, done;
  logic [11:0] dma_addr;
  logic [7:0]  dma_din, buf_din;
  logic [AW:0] buf_addr;

  logic [7:0] vram [4096];
  assign dma_din = vram[dma_addr];

  jtpang_objdma #(.LEN(LEN), .AW(AW), .SRC_BASE(SRC)) dut (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .busrq_n(busrq_n),
    .busak_n(busak_n), .dma_bus(dma_bus), .dma_addr(dma_addr), .dma_din(dma_din),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .obj_page(obj_page),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int wr_cnt = 0, done_cnt = 0, cyc = 0, last_we = -1;
  int cen_div = 1, ak_dly = 3, ak_cnt = 0, cen_cnt = 0;
  bit lost = 0, check_gap = 0;
  logic mdl_page = 1'b0;
  logic [AW:0] exp_a [$];
  logic [7:0]  exp_d [$];
  logic        done_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one transfer copies VRAM[SRC+i] to back-page slot i, then the page flips.
  task automatic push_xfer();
    logic [11:0] a;
    for (int i = 0; i < LEN; i++) begin
      a = SRC + 12'(i);
      exp_a.push_back({~mdl_page, AW'(i)});
      exp_d.push_back(vram[a]);
    end
    done_q.push_back(~mdl_page);
    mdl_page = ~mdl_page;
  endtask

  // CPU bus model and CPU clock enable, driven away from the active edge
  initial forever begin
    @(negedge clk);
    cen_cnt = (cen_cnt + 1) % cen_div;
    cen = (cen_cnt == 0);
    if (busrq_n !== 1'b0) begin
      ak_cnt  = 0;
      busak_n = 1'b1;
    end else begin
      ak_cnt++;
      busak_n = (ak_cnt < ak_dly) || lost;
    end
  end

  // Monitor
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (rst) last_we = -1;
    else begin
      if (buf_we) begin
        wr_cnt++;
        chk("we_bus_owned", 32'(busak_n), 32'd0);
        if (exp_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_write: got addr %0h data %0h expected no write", buf_addr, buf_din);
        end else begin
          chk("buf_addr", 32'(buf_addr), 32'(exp_a.pop_front()));
          chk("buf_din", 32'(buf_din), 32'(exp_d.pop_front()));
        end
        if (check_gap && last_we >= 0) chk("we_gap", 32'(cyc - last_we), 32'(2 * cen_div));
        last_we = cyc;
      end
      if (done) begin
        done_cnt++;
        last_we = -1;
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          chk("page_at_done", 32'(obj_page), 32'(done_q.pop_front()));
          chk("busrq_at_done", 32'(busrq_n), 32'd1);
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 5000) begin
      @(posedge clk); #2; k++;
    end
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_wr(input int target);
    int k = 0;
    while (wr_cnt < target && k < 5000) begin
      @(posedge clk); #2; k++;
    end
    chk("write_timeout", 32'(wr_cnt >= target), 32'd1);
  endtask

  // Go from idle: also checks the two-clock latency to bus request
  task automatic start_go(input int hold);
    @(negedge clk); dma_go = 1'b1;
    @(posedge clk); #2; chk("go_lat1", 32'(busrq_n), 32'd1);
    @(posedge clk); #2; chk("go_lat2", 32'(busrq_n), 32'd0);
    repeat (hold) @(negedge clk);
    dma_go = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk); dma_go = 1'b1;
    @(negedge clk);
    @(negedge clk); dma_go = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle(input string name);
    int d0;
    d0 = done_cnt;
    repeat (30) @(posedge clk);
    #2;
    chk({name, "_no_more_done"}, 32'(done_cnt), 32'(d0));
    chk({name, "_queue_empty"}, 32'(exp_a.size()), 32'd0);
    chk({name, "_page"}, 32'(obj_page), 32'(mdl_page));
  endtask

  initial begin
    int d0, w0;
    logic page_before;
    for (int a = 0; a < 4096; a++) vram[a] = 8'(a) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busrq_n", 32'(busrq_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_dma_bus", 32'(dma_bus), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'(SRC));
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_buf_din", 32'(buf_din), 32'd0);
    chk("rst_obj_page", 32'(obj_page), 32'd0);
    @(negedge clk); rst = 1'b0;

    // basic transfer, VRAM = addr ^ 5A
    check_gap = 1;
    push_xfer();
    start_go(3);
    wait_done(1);
    settle("basic");

    // held go level: one transfer only
    push_xfer();
    start_go(40);
    wait_done(2);
    settle("held");

    // go twice more mid-transfer: exactly one queued transfer
    cen_div = 2;
    d0 = done_cnt; w0 = wr_cnt;
    push_xfer();
    push_xfer();
    start_go(2);
    wait_wr(w0 + 2);
    pulse_go();
    pulse_go();
    wait_done(d0 + 1);
    chk("b2b_busrq_rel", 32'(busrq_n), 32'd1);
    chk("b2b_busy_rel", 32'(busy), 32'd1);
    @(posedge clk); #2;
    chk("b2b_busrq_req", 32'(busrq_n), 32'd0);
    wait_done(d0 + 2);
    settle("b2b");
    chk("b2b_page_end", 32'(obj_page), 32'd0);

    // bus taken away for 20 clk during byte 3
    cen_div = 1; check_gap = 0;
    for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
    d0 = done_cnt; w0 = wr_cnt;
    push_xfer();
    start_go(3);
    wait_wr(w0 + 3);
    @(negedge clk); lost = 1'b1;
    repeat (20) @(negedge clk);
    chk("lost_no_write", 32'(wr_cnt), 32'(w0 + 3));
    chk("lost_busrq_held", 32'(busrq_n), 32'd0);
    lost = 1'b0;
    wait_done(d0 + 1);
    settle("lost");

    // reset in DATA of byte 5, then a clean transfer
    d0 = done_cnt; w0 = wr_cnt;
    page_before = mdl_page;
    push_xfer();
    start_go(3);
    wait_wr(w0 + 5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_a.delete(); exp_d.delete(); done_q.delete();
    mdl_page = page_before;
    @(posedge clk); #2;
    chk("mid_rst_busrq_n", 32'(busrq_n), 32'd1);
    chk("mid_rst_dma_bus", 32'(dma_bus), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_obj_page", 32'(obj_page), 32'd0);
    chk("mid_rst_writes", 32'(wr_cnt), 32'(w0 + 5));
    @(negedge clk); rst = 1'b0;
    // reset returns the page to 0, so the model follows
    mdl_page = 1'b0;
    check_gap = 1;
    push_xfer();
    start_go(3);
    wait_done(d0 + 1);
    settle("post_rst");

    // cen at 1 in 4: writes land exactly 8 clk apart
    cen_div = 4;
    d0 = done_cnt;
    push_xfer();
    start_go(3);
    wait_done(d0 + 1);
    settle("slow_cen");

    // randomised pacing, ack delay and VRAM contents
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
      cen_div = $urandom_range(1, 3);
      ak_dly  = $urandom_range(1, 6);
      d0 = done_cnt;
      push_xfer();
      start_go($urandom_range(2, 30));
      wait_done(d0 + 1);
      settle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
